// File: rtl/bin_ascii_tx_ctrl.sv
// bin_ascii_tx_ctrl -- serializes an 8-bit unsigned value as decimal ASCII
// (hundreds, tens, units) followed by a terminator byte, over a valid/ready
// handshake toward the UART transmitter.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous, active-high reset
//   start     convert-and-send request, sampled only in IDLE
//   dato      value to send (0..255), latched when start is accepted
//   tx_ready  transmitter accepts tx_data this cycle
//   tx_valid  tx_data holds a byte to transfer
//   tx_data   ASCII byte {1'b0, char}
//   busy      high in every state except IDLE
//   done      one-cycle pulse after the terminator has transferred
//
// Build option: define LEADING_ZERO_SUPPRESS_EN to drop leading '0' digits
// (hundreds when zero; tens too when hundreds and tens are both zero).
// Units and terminator are always sent. Undefined: fixed 4-byte frame.

// Binary to three 7-bit ASCII decimal digits.
module Comp_BIN_ASCII (
  input  logic [7:0] bin,
  output logic [6:0] centenas,
  output logic [6:0] decenas,
  output logic [6:0] unidades
);
  logic [3:0] hun, ten, uni;
  logic [6:0] rem;

  always_comb begin
    if (bin >= 8'd200) begin
      hun = 4'd2;
      rem = 7'(bin - 8'd200);
    end else if (bin >= 8'd100) begin
      hun = 4'd1;
      rem = 7'(bin - 8'd100);
    end else begin
      hun = 4'd0;
      rem = bin[6:0];
    end
    // rem < 100: pick the largest multiple of ten not exceeding it
    ten = 4'd0;
    uni = 4'(rem);
    for (int k = 1; k < 10; k++) begin
      if (rem >= 7'(k * 10)) begin
        ten = 4'(k);
        uni = 4'(rem - 7'(k * 10));
      end
    end
  end

  assign centenas = {3'b011, hun};
  assign decenas  = {3'b011, ten};
  assign unidades = {3'b011, uni};
endmodule

module bin_ascii_tx_ctrl #(
  parameter logic [7:0] TERM_CHAR = 8'h0D
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] dato,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       done
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_SEND_C = 3'd2;
  localparam logic [2:0] S_SEND_D = 3'd3;
  localparam logic [2:0] S_SEND_U = 3'd4;
  localparam logic [2:0] S_SEND_T = 3'd5;
  localparam logic [2:0] S_FIN    = 3'd6;

  logic [2:0] state_q, state_d;
  logic [7:0] dato_q, dato_d;
  logic [6:0] cen_q, cen_d, dec_q, dec_d, uni_q, uni_d;
  logic [6:0] cen_c, dec_c, uni_c;

  Comp_BIN_ASCII u_conv (
    .bin      (dato_q),
    .centenas (cen_c),
    .decenas  (dec_c),
    .unidades (uni_c)
  );

  always_comb begin
    state_d = state_q;
    dato_d  = dato_q;
    cen_d   = cen_q;
    dec_d   = dec_q;
    uni_d   = uni_q;
    case (state_q)
      S_IDLE: if (start) begin
        dato_d  = dato;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        cen_d = cen_c;
        dec_d = dec_c;
        uni_d = uni_c;
`ifdef LEADING_ZERO_SUPPRESS_EN
        // Skip decision uses the live converter outputs, since the digit
        // registers only load on this same edge.
        if (cen_c != 7'h30)      state_d = S_SEND_C;
        else if (dec_c != 7'h30) state_d = S_SEND_D;
        else                     state_d = S_SEND_U;
`else
        state_d = S_SEND_C;
`endif
      end
      S_SEND_C: if (tx_ready) state_d = S_SEND_D;
      S_SEND_D: if (tx_ready) state_d = S_SEND_U;
      S_SEND_U: if (tx_ready) state_d = S_SEND_T;
      S_SEND_T: if (tx_ready) state_d = S_FIN;
      S_FIN:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      dato_q  <= 8'h00;
      cen_q   <= 7'h00;
      dec_q   <= 7'h00;
      uni_q   <= 7'h00;
    end else begin
      state_q <= state_d;
      dato_q  <= dato_d;
      cen_q   <= cen_d;
      dec_q   <= dec_d;
      uni_q   <= uni_d;
    end
  end

  // Outputs decode straight from the state flop, so an asserted rst forces
  // them to their idle values without waiting for a clock edge.
  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    case (state_q)
      S_SEND_C: begin tx_valid = 1'b1; tx_data = {1'b0, cen_q}; end
      S_SEND_D: begin tx_valid = 1'b1; tx_data = {1'b0, dec_q}; end
      S_SEND_U: begin tx_valid = 1'b1; tx_data = {1'b0, uni_q}; end
      S_SEND_T: begin tx_valid = 1'b1; tx_data = TERM_CHAR;     end
      default:  ;
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_FIN);
endmodule

// File: tb/tb_bin_ascii_tx_ctrl.sv
module tb_bin_ascii_tx_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dato;
  logic       tx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       busy;
  logic       done;

  int errs   = 0;
  int checks = 0;
  int cyc    = 0;

  logic [7:0] got_q[$];
  int         got_edge[$];
  int         done_cnt = 0;
  int         last_done_cyc = -1;
  int         stab_err = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  bin_ascii_tx_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dato     (dato),
    .tx_ready (tx_ready),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Inputs only change #1 after a rising edge, so what is seen here is what
  // the next rising edge will act on; the recorded edge is that next edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!tx_valid || tx_data !== prev_data)) stab_err++;
      if (tx_valid && tx_ready) begin
        got_q.push_back(tx_data);
        got_edge.push_back(cyc + 1);
      end
      if (done) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  task automatic clear_log;
    got_q.delete();
    got_edge.delete();
  endtask

  // Waits (bounded) for the done pulse, then steps past FIN into IDLE.
  task automatic wait_done(output bit to);
    to = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        to = 1'b0;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    #3;
    checks++; if (tx_valid !== 1'b0) begin errs++; $display("FAIL reset_tx_valid got=%b want=0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errs++; $display("FAIL reset_tx_data got=%h want=00", tx_data); end
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin errs++; $display("FAIL reset_done got=%b want=0", done); end
    @(negedge clk); rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL idle_no_start_busy got=%b want=0", busy); end
  endtask

  task automatic test_basic;
    int n, d0;
    bit to;
    logic [31:0] e;
    e = 32'h3137330D;
    clear_log();
    d0 = done_cnt;
    tx_ready = 1'b1;
    @(posedge clk); #1; dato = 8'd173; start = 1'b1;
    @(posedge clk); #1; n = cyc; start = 1'b0; dato = 8'hFF;
    checks++; if (busy !== 1'b1 || tx_valid !== 1'b0) begin errs++; $display("FAIL load_state busy=%b tx_valid=%b want busy=1 tx_valid=0", busy, tx_valid); end
    @(posedge clk); #1;
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h31) begin errs++; $display("FAIL first_valid tx_valid=%b tx_data=%h want 1/31", tx_valid, tx_data); end
    wait_done(to);
    checks++; if (to) begin errs++; $display("FAIL basic_timeout no done pulse"); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errs++; $display("FAIL basic_after_fin busy=%b done=%b want 0/0", busy, done); end
    checks++; if (got_q.size() != 4) begin errs++; $display("FAIL basic_len got=%0d want=4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== e[8*(3-i) +: 8] || got_edge[i] != n + 2 + i)
        begin errs++; $display("FAIL basic_byte%0d got=%h@%0d want=%h@%0d", i, got_q[i], got_edge[i], e[8*(3-i) +: 8], n + 2 + i); end
    end
    checks++; if (last_done_cyc != n + 5 || done_cnt != d0 + 1) begin errs++; $display("FAIL basic_done cyc=%0d cnt=%0d want cyc=%0d cnt=%0d", last_done_cyc, done_cnt - d0, n + 5, 1); end
  endtask

  // One directed conversion; e holds up to four expected bytes, MSB first.
  task automatic test_digits(input logic [7:0] v, input logic [31:0] e, input int len);
    int n, d0;
    bit to;
    clear_log();
    d0 = done_cnt;
    tx_ready = 1'b1;
    @(posedge clk); #1; dato = v; start = 1'b1;
    @(posedge clk); #1; n = cyc; start = 1'b0; dato = ~v;
    wait_done(to);
    checks++; if (to) begin errs++; $display("FAIL digits_%0d_timeout", v); end
    checks++; if (got_q.size() != len) begin errs++; $display("FAIL digits_%0d_len got=%0d want=%0d", v, got_q.size(), len); end
    for (int i = 0; i < len && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== e[8*(3-i) +: 8]) begin errs++; $display("FAIL digits_%0d_byte%0d got=%h want=%h", v, i, got_q[i], e[8*(3-i) +: 8]); end
    end
    checks++; if (last_done_cyc != n + 1 + len || done_cnt != d0 + 1) begin errs++; $display("FAIL digits_%0d_done cyc=%0d want=%0d", v, last_done_cyc, n + 1 + len); end
  endtask

  task automatic test_stall;
    int d0, se0, len;
    bit to;
    logic [31:0] e;
`ifdef LEADING_ZERO_SUPPRESS_EN
    e = 32'h34320D00; len = 3;
`else
    e = 32'h3034320D; len = 4;
`endif
    clear_log();
    d0 = done_cnt;
    se0 = stab_err;
    @(posedge clk); #1; dato = 8'd42; start = 1'b1; tx_ready = 1'b0;
    @(posedge clk); #1; start = 1'b0; dato = 8'd99;
    to = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) begin
        to = 1'b0;
        break;
      end
      @(posedge clk); #1;
      tx_ready = (i < 4) ? 1'b0 : 1'($urandom_range(0, 1));
    end
    tx_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (to) begin errs++; $display("FAIL stall_timeout"); end
    checks++; if (got_q.size() != len) begin errs++; $display("FAIL stall_len got=%0d want=%0d", got_q.size(), len); end
    for (int i = 0; i < len && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== e[8*(3-i) +: 8]) begin errs++; $display("FAIL stall_byte%0d got=%h want=%h", i, got_q[i], e[8*(3-i) +: 8]); end
    end
    checks++; if (stab_err != se0) begin errs++; $display("FAIL stall_stability violations=%0d want=0", stab_err - se0); end
    checks++; if (done_cnt != d0 + 1) begin errs++; $display("FAIL stall_done_count got=%0d want=1", done_cnt - d0); end
  endtask

  task automatic test_ignore_start;
    int d0;
    bit to;
    logic [31:0] e;
    e = 32'h3137330D;
    clear_log();
    d0 = done_cnt;
    tx_ready = 1'b1;
    @(posedge clk); #1; dato = 8'd173; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) @(posedge clk);
    #1; dato = 8'd7; start = 1'b1;   // now in SEND_D
    @(posedge clk); #1; start = 1'b0;
    wait_done(to);
    repeat (4) @(posedge clk);
    #1;
    checks++; if (to) begin errs++; $display("FAIL ignore_timeout"); end
    checks++; if (got_q.size() != 4 || busy !== 1'b0) begin errs++; $display("FAIL ignore_len got=%0d busy=%b want 4/0", got_q.size(), busy); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== e[8*(3-i) +: 8]) begin errs++; $display("FAIL ignore_byte%0d got=%h want=%h", i, got_q[i], e[8*(3-i) +: 8]); end
    end
    checks++; if (done_cnt != d0 + 1) begin errs++; $display("FAIL ignore_done_count got=%0d want=1", done_cnt - d0); end
  endtask

  task automatic test_reset_mid;
    int d0, len;
    bit to;
    logic [31:0] e;
`ifdef LEADING_ZERO_SUPPRESS_EN
    e = 32'h390D0000; len = 2;
`else
    e = 32'h3030390D; len = 4;
`endif
    d0 = done_cnt;
    tx_ready = 1'b1;
    @(posedge clk); #1; dato = 8'd173; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (tx_data !== 8'h33) begin errs++; $display("FAIL rstmid_in_send_u tx_data=%h want=33", tx_data); end
    rst = 1'b1;
    #1;
    checks++; if (tx_valid !== 1'b0 || busy !== 1'b0 || tx_data !== 8'h00 || done !== 1'b0)
      begin errs++; $display("FAIL rstmid_async tx_valid=%b busy=%b tx_data=%h done=%b want 0/0/00/0", tx_valid, busy, tx_data, done); end
    repeat (2) @(posedge clk);
    clear_log();
    @(negedge clk); rst = 1'b0; dato = 8'd9; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    checks++; if (busy !== 1'b1) begin errs++; $display("FAIL rstmid_first_start busy=%b want=1", busy); end
    wait_done(to);
    checks++; if (to) begin errs++; $display("FAIL rstmid_timeout"); end
    checks++; if (got_q.size() != len) begin errs++; $display("FAIL rstmid_len got=%0d want=%0d", got_q.size(), len); end
    for (int i = 0; i < len && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== e[8*(3-i) +: 8]) begin errs++; $display("FAIL rstmid_byte%0d got=%h want=%h", i, got_q[i], e[8*(3-i) +: 8]); end
    end
    checks++; if (done_cnt != d0 + 1) begin errs++; $display("FAIL rstmid_done_count got=%0d want=1", done_cnt - d0); end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    dato = 8'h00;
    tx_ready = 1'b1;
    test_reset();
    test_basic();
`ifdef LEADING_ZERO_SUPPRESS_EN
    test_digits(8'd5,   32'h350D0000, 2);
    test_digits(8'd0,   32'h300D0000, 2);
    test_digits(8'd42,  32'h34320D00, 3);
`else
    test_digits(8'd5,   32'h3030350D, 4);
    test_digits(8'd0,   32'h3030300D, 4);
    test_digits(8'd42,  32'h3034320D, 4);
`endif
    test_digits(8'd255, 32'h3235350D, 4);
    test_digits(8'd100, 32'h3130300D, 4);
    test_digits(8'd199, 32'h3139390D, 4);
    test_stall();
    test_ignore_start();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
